// File: rtl/bool_sop_engine_if.sv
// Evaluation, configuration and sweep signals of bool_sop_engine.
// The master side drives requests; the slave side is the engine.
interface bool_sop_engine_if #(
    parameter int N_IN = 3
);
    localparam int T = 1 << N_IN;

    logic            in_valid;
    logic [N_IN-1:0] in_vec;
    logic            out_valid;
    logic            out_f;
    logic            cfg_bit_we;
    logic [N_IN-1:0] cfg_idx;
    logic            cfg_bit;
    logic            cfg_mask_we;
    logic [T-1:0]    cfg_mask;
    logic            sweep_start;
    logic            sweep_busy;
    logic            sweep_done;
    logic            min_valid;
    logic [N_IN-1:0] min_idx;
    logic [N_IN:0]   min_count;

    modport master (
        output in_valid, in_vec,
        output cfg_bit_we, cfg_idx, cfg_bit,
        output cfg_mask_we, cfg_mask,
        output sweep_start,
        input  out_valid, out_f,
        input  sweep_busy, sweep_done,
        input  min_valid, min_idx, min_count
    );

    modport slave (
        input  in_valid, in_vec,
        input  cfg_bit_we, cfg_idx, cfg_bit,
        input  cfg_mask_we, cfg_mask,
        input  sweep_start,
        output out_valid, out_f,
        output sweep_busy, sweep_done,
        output min_valid, min_idx, min_count
    );
endinterface

// File: rtl/bool_sop_engine.sv
// Programmable sum-of-minterms evaluator with a truth-table mask
// and a sweep FSM that enumerates and counts the stored minterms.
module bool_sop_engine #(
    parameter int         N_IN      = 3,
    parameter logic [255:0] INIT_MASK = 256'h65
) (
    input  logic            clk,
    input  logic            rst_n,
    bool_sop_engine_if.slave bus
);
    localparam int T  = 1 << N_IN;
    localparam int CW = N_IN + 1;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [T-1:0]    mask_q;
    logic [T-1:0]    mask_d;
    logic [N_IN-1:0] scan_q;
    logic [CW-1:0]   count_q;
    logic            start_ok;
    logic            cfg_ok;
    logic            hit;
    logic            out_valid_q;
    logic            out_f_q;
    logic            min_valid_q;
    logic [N_IN-1:0] min_idx_q;

    assign hit    = mask_q[scan_q];
    // The mask is frozen from the accepting cycle until the sweep ends.
    assign cfg_ok = (state_q == IDLE) && !bus.sweep_start;

    always_comb begin
        state_d  = state_q;
        start_ok = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.sweep_start) begin
                    state_d  = SCAN;
                    start_ok = 1'b1;
                end
            end
            SCAN: begin
                if (&scan_q) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Bulk write first, then the bit write overrides its one position.
    always_comb begin
        mask_d = mask_q;
        if (cfg_ok) begin
            if (bus.cfg_mask_we) mask_d = bus.cfg_mask;
            if (bus.cfg_bit_we)  mask_d[bus.cfg_idx] = bus.cfg_bit;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            mask_q      <= INIT_MASK[T-1:0];
            scan_q      <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            out_f_q     <= 1'b0;
            min_valid_q <= 1'b0;
            min_idx_q   <= '0;
        end else begin
            state_q     <= state_d;
            mask_q      <= mask_d;
            out_valid_q <= bus.in_valid;
            if (bus.in_valid) out_f_q <= mask_q[bus.in_vec];
            min_valid_q <= (state_q == SCAN) && hit;
            if (start_ok) begin
                scan_q  <= '0;
                count_q <= '0;
            end else if (state_q == SCAN) begin
                scan_q    <= scan_q + N_IN'(1);
                count_q   <= count_q + CW'(hit);
                min_idx_q <= scan_q;
            end
        end
    end

    assign bus.out_valid  = out_valid_q;
    assign bus.out_f      = out_f_q;
    assign bus.sweep_busy = (state_q != IDLE);
    assign bus.sweep_done = (state_q == DONE);
    assign bus.min_valid  = min_valid_q;
    assign bus.min_idx    = min_idx_q;
    assign bus.min_count  = count_q;
endmodule

// File: tb/tb_bool_sop_engine.sv
// Randomised self-checking bench for bool_sop_engine against a
// truth-table model held as a plain bit vector.
module tb_bool_sop_engine;
    localparam int N_IN = 3;
    localparam int T    = 1 << N_IN;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    bool_sop_engine_if #(.N_IN(N_IN)) bus ();

    bool_sop_engine #(
        .N_IN(N_IN),
        .INIT_MASK(256'h65)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;
    logic [T-1:0] m_mask;
    logic         m_f;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.in_valid    = 1'b0;
        bus.in_vec      = '0;
        bus.cfg_bit_we  = 1'b0;
        bus.cfg_idx     = '0;
        bus.cfg_bit     = 1'b0;
        bus.cfg_mask_we = 1'b0;
        bus.cfg_mask    = '0;
        bus.sweep_start = 1'b0;
    endtask

    task automatic test_reset();
        logic [N_IN+6:0] got;
        rst_n = 1'b0;
        idle_inputs();
        tick();
        tick();
        got = {bus.out_valid, bus.out_f, bus.sweep_busy, bus.sweep_done,
               bus.min_valid, bus.min_idx, bus.min_count};
        checks++;
        if (got !== '0) begin
            errors++;
            $display("FAIL reset_outputs got %h want 0", got);
        end
        rst_n  = 1'b1;
        m_mask = 8'h65;
        m_f    = 1'b0;
    endtask

    task automatic test_eval_vectors();
        int vecs[6] = '{0, 1, 2, 5, 6, 7};
        logic e;
        foreach (vecs[i]) begin
            bus.in_valid = 1'b1;
            bus.in_vec   = N_IN'(vecs[i]);
            e = m_mask[vecs[i]];
            tick();
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_f !== e) begin
                errors++;
                $display("FAIL eval_vec%0d got v=%b f=%b want v=1 f=%b",
                         vecs[i], bus.out_valid, bus.out_f, e);
            end
            m_f = e;
        end
        bus.in_valid = 1'b0;
        tick();
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_f !== m_f) begin
            errors++;
            $display("FAIL eval_hold got v=%b f=%b want v=0 f=%b",
                     bus.out_valid, bus.out_f, m_f);
        end
    endtask

    task automatic test_sweep(input bit disturb);
        logic [T-1:0] got_bits = '0;
        int n_emit = 0;
        int last   = -1;
        bit order_ok = 1'b1;
        int done_at  = -1;
        bit busy_ok  = 1'b1;
        bit pend_v = 1'b0;
        logic pend_f = 1'b0;
        int exp_cnt = $countones(m_mask);
        bus.sweep_start = 1'b1;
        if (disturb) begin
            bus.cfg_bit_we = 1'b1;
            bus.cfg_idx    = N_IN'($urandom_range(T - 1));
            bus.cfg_bit    = ~m_mask[bus.cfg_idx];
        end
        tick();
        idle_inputs();
        for (int k = 1; k <= T + 1; k++) begin
            if (bus.sweep_busy !== 1'b1) busy_ok = 1'b0;
            if (bus.sweep_done === 1'b1) done_at = k;
            if (bus.min_valid === 1'b1) begin
                if (int'(bus.min_idx) <= last) order_ok = 1'b0;
                last = int'(bus.min_idx);
                got_bits[bus.min_idx] = 1'b1;
                n_emit++;
            end
            if (pend_v) begin
                checks++;
                if (bus.out_valid !== 1'b1 || bus.out_f !== pend_f) begin
                    errors++;
                    $display("FAIL sweep_eval k=%0d got v=%b f=%b want f=%b",
                             k, bus.out_valid, bus.out_f, pend_f);
                end
            end
            if (k == T + 1) begin
                checks++;
                if (bus.min_count !== (N_IN + 1)'(exp_cnt)) begin
                    errors++;
                    $display("FAIL sweep_count_at_done got %0d want %0d",
                             bus.min_count, exp_cnt);
                end
            end
            idle_inputs();
            if (disturb) begin
                bus.in_valid = 1'($urandom_range(1));
                bus.in_vec   = N_IN'($urandom_range(T - 1));
                pend_v = bus.in_valid;
                pend_f = m_mask[bus.in_vec];
                if (k == 2) begin
                    bus.cfg_mask_we = 1'b1;
                    bus.cfg_mask    = '0;
                    bus.sweep_start = 1'b1;
                end
            end
            tick();
        end
        if (pend_v) begin
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_f !== pend_f) begin
                errors++;
                $display("FAIL sweep_eval_last got f=%b want %b",
                         bus.out_f, pend_f);
            end
            m_f = pend_f;
        end
        idle_inputs();
        checks++;
        if (!busy_ok || bus.sweep_busy !== 1'b0) begin
            errors++;
            $display("FAIL sweep_busy window ok=%0d end=%b want ok=1 end=0",
                     busy_ok, bus.sweep_busy);
        end
        checks++;
        if (done_at != T + 1 || bus.sweep_done !== 1'b0) begin
            errors++;
            $display("FAIL sweep_done_time got %0d want %0d", done_at, T + 1);
        end
        checks++;
        if (got_bits !== m_mask || n_emit != exp_cnt || !order_ok) begin
            errors++;
            $display("FAIL sweep_minterms got %h n=%0d ord=%0d want %h n=%0d",
                     got_bits, n_emit, order_ok, m_mask, exp_cnt);
        end
        checks++;
        if (bus.min_valid !== 1'b0 ||
            bus.min_count !== (N_IN + 1)'(exp_cnt)) begin
            errors++;
            $display("FAIL sweep_after got mv=%b cnt=%0d want mv=0 cnt=%0d",
                     bus.min_valid, bus.min_count, exp_cnt);
        end
    endtask

    task automatic test_cfg_writes();
        logic e;
        bus.in_valid   = 1'b1;
        bus.in_vec     = 3'b111;
        bus.cfg_bit_we = 1'b1;
        bus.cfg_idx    = 3'd7;
        bus.cfg_bit    = 1'b1;
        e = m_mask[7];
        tick();
        m_mask[7] = 1'b1;
        checks++;
        if (bus.out_f !== e) begin
            errors++;
            $display("FAIL cfg_read_before_write got %b want %b", bus.out_f, e);
        end
        idle_inputs();
        bus.in_valid = 1'b1;
        bus.in_vec   = 3'b111;
        tick();
        checks++;
        if (bus.out_f !== m_mask[7]) begin
            errors++;
            $display("FAIL cfg_bit_effect got %b want %b",
                     bus.out_f, m_mask[7]);
        end
        m_f = m_mask[7];
        idle_inputs();
        test_sweep(1'b0);
        bus.cfg_mask_we = 1'b1;
        bus.cfg_mask    = 8'h00;
        tick();
        m_mask = 8'h00;
        idle_inputs();
        test_sweep(1'b0);
        bus.cfg_mask_we = 1'b1;
        bus.cfg_mask    = 8'hFF;
        bus.cfg_bit_we  = 1'b1;
        bus.cfg_idx     = 3'd3;
        bus.cfg_bit     = 1'b0;
        tick();
        m_mask    = 8'hFF;
        m_mask[3] = 1'b0;
        idle_inputs();
        test_sweep(1'b0);
    endtask

    task automatic test_sweep_disturbed();
        bus.cfg_mask_we = 1'b1;
        bus.cfg_mask    = 8'h65;
        tick();
        m_mask = 8'h65;
        idle_inputs();
        test_sweep(1'b1);
    endtask

    task automatic test_random();
        logic ev;
        logic ef;
        for (int n = 0; n < 150; n++) begin
            bus.in_valid    = (n == 0) ? 1'b1 : 1'($urandom_range(1));
            bus.in_vec      = N_IN'($urandom_range(T - 1));
            bus.cfg_mask_we = ($urandom_range(3) == 0);
            bus.cfg_mask    = T'($urandom);
            bus.cfg_bit_we  = ($urandom_range(2) == 0);
            bus.cfg_idx     = N_IN'($urandom_range(T - 1));
            bus.cfg_bit     = 1'($urandom_range(1));
            ev = bus.in_valid;
            ef = ev ? m_mask[bus.in_vec] : m_f;
            if (bus.cfg_mask_we) m_mask = bus.cfg_mask;
            if (bus.cfg_bit_we)  m_mask[bus.cfg_idx] = bus.cfg_bit;
            tick();
            checks++;
            if (bus.out_valid !== ev || bus.out_f !== ef) begin
                errors++;
                $display("FAIL random_eval n=%0d got v=%b f=%b want v=%b f=%b",
                         n, bus.out_valid, bus.out_f, ev, ef);
            end
            m_f = ef;
            if (n % 50 == 49) begin
                idle_inputs();
                test_sweep(1'b0);
            end
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid_sweep();
        bit done_seen = 1'b0;
        logic [N_IN+5:0] got;
        bus.cfg_mask_we = 1'b1;
        bus.cfg_mask    = 8'h3C;
        tick();
        idle_inputs();
        bus.sweep_start = 1'b1;
        tick();
        bus.sweep_start = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        got = {bus.sweep_busy, bus.sweep_done, bus.min_valid, bus.min_count};
        checks++;
        if (got !== '0) begin
            errors++;
            $display("FAIL midsweep_reset got %h want 0", got);
        end
        for (int k = 0; k < 2 * T; k++) begin
            tick();
            if (bus.sweep_done === 1'b1 || bus.sweep_busy === 1'b1)
                done_seen = 1'b1;
        end
        checks++;
        if (done_seen) begin
            errors++;
            $display("FAIL midsweep_no_done got 1 want 0");
        end
        m_mask = 8'h65;
        for (int v = 0; v < T; v++) begin
            bus.in_valid = 1'b1;
            bus.in_vec   = N_IN'(v);
            tick();
            checks++;
            if (bus.out_f !== m_mask[v]) begin
                errors++;
                $display("FAIL midsweep_mask v=%0d got %b want %b",
                         v, bus.out_f, m_mask[v]);
            end
        end
        idle_inputs();
        tick();
    endtask

    initial begin
        test_reset();
        test_eval_vectors();
        test_sweep(1'b0);
        test_cfg_writes();
        test_sweep_disturbed();
        test_random();
        test_reset_mid_sweep();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/bool_sop_engine.md
Name: bool_sop_engine

Overview:
- Parametrised, programmable sum-of-minterms evaluator for an N_IN-input Boolean function F.
- The minterm set is held in a 2^N_IN-bit truth-table mask register, loaded by single-bit or bulk writes.
- Each input vector is evaluated with a registered 1-cycle latency.
- A sweep FSM enumerates the stored minterms in ascending order, streams them out, and reports their count. Used as the generic replacement for fixed three-input minterm blocks.

Parameters:
- N_IN, 3, number of function inputs (1..8); table depth T = 2^N_IN.
- INIT_MASK, 8'h65, truth-table mask loaded at reset. Bit k=1 means minterm k is in F. Default = Σ(0,2,5,6). Width T; zero-extended or truncated to T.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  evaluation request
- in_vec  in  N_IN  input vector; MSB = first variable (A), LSB = last (C for N_IN=3)
- out_valid  out  1  evaluation result valid
- out_f  out  1  F(in_vec)
- cfg_bit_we  in  1  single-minterm write enable
- cfg_idx  in  N_IN  minterm index for single write
- cfg_bit  in  1  value written to mask[cfg_idx]
- cfg_mask_we  in  1  bulk mask write enable
- cfg_mask  in  T  bulk mask value
- sweep_start  in  1  start minterm enumeration (pulse)
- sweep_busy  out  1  sweep FSM not IDLE
- sweep_done  out  1  one-cycle pulse at sweep end
- min_valid  out  1  min_idx is a minterm of F
- min_idx  out  N_IN  enumerated minterm index
- min_count  out  N_IN+1  number of minterms found by the last sweep

Behaviour:
- Reset (rst_n=0 at a clk edge): mask=INIT_MASK; state=IDLE.
  - out_valid=0, out_f=0, sweep_busy=0, sweep_done=0, min_valid=0, min_idx=0, min_count=0.
  - Reset overrides every other input, including mid-sweep: the sweep is aborted and no done pulse is issued.
- Evaluation:
  - in_valid=1 at edge t gives out_valid=1 and out_f=mask[in_vec] at t+1.
  - in_valid=0 gives out_valid=0 next cycle; out_f holds its last value.
  - Evaluation is fully pipelined (one result per cycle) and operates during sweeps.
- Config writes:
  - Writes take effect at the edge.
  - An evaluation in the same cycle as a write uses the pre-write mask (read-before-write).
  - If cfg_mask_we and cfg_bit_we are both asserted: the bulk write is applied first, then the bit write overrides bit cfg_idx.
  - All config writes are ignored while sweep_busy=1, or in the cycle sweep_start is accepted. This keeps the enumeration consistent.
- Sweep FSM states: IDLE, SCAN, DONE.
  - IDLE -> SCAN on sweep_start=1. Scan index s=0 and min_count=0 are set at that edge.
  - SCAN:
    - Each cycle, register min_valid=mask[s] and min_idx=s for the next cycle.
    - min_count increments when mask[s]=1.
    - When s=T-1, go to DONE; otherwise s=s+1.
    - SCAN lasts exactly T cycles.
  - DONE (1 cycle): sweep_done=1. The last min_valid emission appears in this cycle. Next state is IDLE.
  - sweep_busy=1 in SCAN and DONE.
  - sweep_start while busy is ignored.
  - min_valid=0 whenever the previous cycle was not SCAN. min_idx holds its last value.
- Timing: with start sampled at edge t, sweep_done is high during cycle t+T+1. min_count is final at that point and holds until the next accepted start.
- Width and boundary cases:
  - min_count is N_IN+1 bits so that a full mask yields T without overflow.
  - An empty mask gives no min_valid and min_count=0, with the same timing.
  - s wraps at T-1 and is never exceeded.

Test Plan:
- Reset, default mask, N_IN=3: in_vec 000,001,010,101,110,111 on consecutive cycles -> out_f 1,0,1,1,1,0, each one cycle later, out_valid continuous.
- Reset, sweep_start at edge t -> min_valid pulses with min_idx 0,2,5,6; sweep_done high at t+9; min_count=4; sweep_busy high cycles t+1..t+9.
- cfg_bit_we idx=7 bit=1 with in_vec=111 in the same cycle -> out_f=0 (old mask); next eval of 111 -> 1; sweep -> min_count=5.
- cfg_mask_we=8'h00 then sweep -> no min_valid, done at t+9, min_count=0. cfg_mask_we=8'hFF together with cfg_bit_we idx=3 bit=0 -> mask=8'hF7; sweep -> min_count=7.
- During a sweep: cfg_mask_we=8'h00 and a second sweep_start -> both ignored; sweep still yields 0,2,5,6 and count 4. Evaluations during the sweep remain correct.
- rst_n=0 at SCAN cycle 3 -> next cycle sweep_busy=0, min_valid=0, min_count=0, mask=8'h65, and no sweep_done pulse.
